// File: rtl/proc_mem_pkg.sv
// Package: proc_mem_pkg
// Definitions shared by the multicycle core and its data-memory responder.
//   mem_state_t  - 2-bit encoding of the responder handshake FSM
//   DMEM_BASE    - byte address of word 0 of the data segment
//   WSTRB_WORD   - byte-enable pattern for a full-word store
//   in_window    - true when a byte offset lies inside a span of bytes
package proc_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2,
    ST_HOLD = 2'd3
  } mem_state_t;

  localparam logic [31:0] DMEM_BASE  = 32'h1001_0000;
  localparam logic [3:0]  WSTRB_WORD = 4'hF;

  // The span is 33 bits wide so that a window covering the whole 32-bit
  // space can still be expressed. An offset produced by an address below
  // the base has already wrapped to a large value and lands outside.
  function automatic logic in_window(input logic [31:0] off,
                                     input logic [32:0] span);
    return ({1'b0, off} < span);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Module: dmem_array
// DEPTH_WORDS x 32-bit data storage with per-byte write enables and a
// registered read port. Contents are never reset.
//   clk    in   clock, rising edge
//   we     in   write enable (qualified per byte by wstrb)
//   wstrb  in   byte enables; bit i writes wdata[8i+7:8i]
//   idx    in   word index used by both the write and the read
//   wdata  in   write data
//   re     in   read enable; rdata updates on the same edge
//   rdata  out  registered read data, holds when re=0
module dmem_array #(
  parameter int DEPTH_WORDS = 128,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [3:0]       wstrb,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  input  logic             re,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) begin
          mem[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
    if (re) begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Module: dmem_responder
// Data-memory responder for the multicycle core's load/store port. A level
// request (mem_read / mem_write) is accepted in IDLE, held for WAIT_STATES
// cycles, answered with a one-cycle ready pulse, and then the responder waits
// in HOLD until the core drops the request (4-phase handshake).
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   mem_read   in   load request, held until ready seen
//   mem_write  in   store request, held until ready seen
//   addr       in   byte address (word aligned for a valid access)
//   wdata      in   store data
//   wstrb      in   store byte enables
//   rdata      out  load data, qualified by ready & ~err
//   ready      out  one-cycle response strobe
//   err        out  access fault, qualified by ready
module dmem_responder
  import proc_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DMEM_BASE,
  parameter int          DEPTH_WORDS = 128,
  parameter int          WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err
);

  localparam int          IDX_W  = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN   = 33'(4 * DEPTH_WORDS);
  localparam logic [3:0]  WS_CNT = 4'(WAIT_STATES);

  mem_state_t state_reg, state_next;
  logic [3:0] count_reg, count_next;

  // Request latches, captured only on the accept edge.
  logic             is_write_reg;
  logic             fault_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [31:0]      wdata_reg;
  logic [3:0]       wstrb_reg;

  logic [31:0]      rdata_reg;

  // Decode of the live bus, used only while IDLE.
  logic             req;
  logic [31:0]      live_off;
  logic             live_fault;
  logic [IDX_W-1:0] live_idx;

  // Storage port.
  logic             arr_we;
  logic             arr_re;
  logic [IDX_W-1:0] arr_idx;
  logic [31:0]      arr_wdata;
  logic [3:0]       arr_wstrb;
  logic [31:0]      arr_rdata;

  logic             in_idle;
  logic             resp_drives_rdata;
  logic [31:0]      resp_rdata;

  assign req        = mem_read | mem_write;
  assign live_off   = addr - BASE_ADDR;
  assign live_fault = (addr[1:0] != 2'b00) | ~in_window(live_off, SPAN)
                    | (mem_read & mem_write);
  assign live_idx   = live_off[IDX_W+1:2];

  // With zero wait states the access happens on the accept edge itself, so
  // the storage port must be fed from the live bus rather than the latches.
  assign in_idle   = (state_reg == ST_IDLE);
  assign arr_idx   = in_idle ? live_idx : idx_reg;
  assign arr_wdata = in_idle ? wdata    : wdata_reg;
  assign arr_wstrb = in_idle ? wstrb    : wstrb_reg;

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    arr_we     = 1'b0;
    arr_re     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (req) begin
          if (WAIT_STATES == 0) begin
            state_next = ST_RESP;
            count_next = 4'd0;
            arr_we     = mem_write & ~live_fault;
            arr_re     = mem_read & ~live_fault;
          end else begin
            state_next = ST_WAIT;
            count_next = WS_CNT;
          end
        end
      end
      ST_WAIT: begin
        count_next = count_reg - 4'd1;
        // The store commits and the load is issued on the edge entering
        // RESP, so the registered read data is ready during RESP.
        if (count_reg <= 4'd1) begin
          state_next = ST_RESP;
          count_next = 4'd0;
          arr_we     = is_write_reg & ~fault_reg;
          arr_re     = ~is_write_reg & ~fault_reg;
        end
      end
      ST_RESP: begin
        state_next = ST_HOLD;
      end
      ST_HOLD: begin
        if (!req) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      count_reg    <= 4'd0;
      is_write_reg <= 1'b0;
      fault_reg    <= 1'b0;
      idx_reg      <= '0;
      wdata_reg    <= 32'd0;
      wstrb_reg    <= 4'd0;
      rdata_reg    <= 32'd0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      if (in_idle && req) begin
        is_write_reg <= mem_write;
        fault_reg    <= live_fault;
        idx_reg      <= live_idx;
        wdata_reg    <= wdata;
        wstrb_reg    <= wstrb & WSTRB_WORD;
      end
      if (resp_drives_rdata) begin
        rdata_reg <= resp_rdata;
      end
    end
  end

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .wstrb (arr_wstrb),
    .idx   (arr_idx),
    .wdata (arr_wdata),
    .re    (arr_re),
    .rdata (arr_rdata)
  );

  // Loads and faults present a value in RESP; a good store leaves rdata at
  // whatever the last response showed. The held copy makes rdata stable
  // outside RESP and zero straight out of reset.
  assign resp_drives_rdata = (state_reg == ST_RESP) & (fault_reg | ~is_write_reg);
  assign resp_rdata        = fault_reg ? 32'd0 : arr_rdata;

  assign ready = (state_reg == ST_RESP);
  assign err   = ready & fault_reg;
  assign rdata = resp_drives_rdata ? resp_rdata : rdata_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench: tb_dmem_responder
// Three responders (WAIT_STATES = 1, 0, 3) share one request bus. The driver
// pushes the expected response of every request into a per-instance queue
// computed from a word-array reference model; a per-instance monitor pops
// and compares whenever that instance raises ready.
module tb_dmem_responder;

  localparam logic [31:0] BASE  = 32'h1001_0000;
  localparam int          DEPTH = 128;
  localparam int          NI    = 3;

  typedef struct {
    bit          is_load;
    bit          is_fault;
    logic [31:0] rdata;
    logic [31:0] addr;
    int          accept_cyc;
    int          id;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [31:0] addr, wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata_v [NI];
  logic        ready_v [NI];
  logic        err_v   [NI];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int txn_id = 0;
  int resp_cnt [NI];
  exp_t sb_q [NI][$];
  logic [31:0] model_mem [NI][DEPTH];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int WS = (gi == 0) ? 1 : ((gi == 1) ? 0 : 3);
    exp_t e;
    int   lat;
    logic prev_ready = 1'b0;

    dmem_responder #(
      .BASE_ADDR   (BASE),
      .DEPTH_WORDS (DEPTH),
      .WAIT_STATES (WS)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .addr      (addr),
      .wdata     (wdata),
      .wstrb     (wstrb),
      .rdata     (rdata_v[gi]),
      .ready     (ready_v[gi]),
      .err       (err_v[gi])
    );

    always @(negedge clk) begin
      if (ready_v[gi] === 1'b1) begin
        checks++;
        if (prev_ready === 1'b1) begin
          errors++;
          $display("FAIL ready_width ws=%0d ready high %0d cycles, required 1", WS, 2);
        end
        checks++;
        if (sb_q[gi].size() == 0) begin
          errors++;
          $display("FAIL extra_ready ws=%0d got ready err=%b rdata=%h, required no response",
                   WS, err_v[gi], rdata_v[gi]);
        end else begin
          e   = sb_q[gi].pop_front();
          lat = cyc + 1 - e.accept_cyc;
          resp_cnt[gi]++;
          if (err_v[gi] !== e.is_fault || lat != WS + 1 ||
              ((e.is_load || e.is_fault) && rdata_v[gi] !== e.rdata)) begin
            errors++;
            $display("FAIL resp ws=%0d id=%0d addr=%h got err=%b rdata=%h lat=%0d, required err=%b rdata=%h lat=%0d",
                     WS, e.id, e.addr, err_v[gi], rdata_v[gi], lat,
                     e.is_fault, e.rdata, WS + 1);
          end else begin
            $display("ws=%0d id=%0d %s addr=%h err=%b rdata=%h lat=%0d",
                     WS, e.id, e.is_load ? "LD" : "ST", e.addr, err_v[gi],
                     rdata_v[gi], lat);
          end
        end
      end
      prev_ready = ready_v[gi];
    end
  end

  // Builds the expected response from the decode rules and updates the model.
  task automatic push_expect(input bit rd, input bit wr, input logic [31:0] a,
                             input logic [31:0] d, input logic [3:0] s,
                             input bit [NI-1:0] commit_mask);
    logic [31:0] off;
    bit          fault;
    int          idx;
    exp_t        e;
    off   = a - BASE;
    fault = (a % 4 != 0) || (off >= 32'(4 * DEPTH)) || (rd && wr);
    idx   = fault ? 0 : int'(off / 4);
    txn_id++;
    for (int i = 0; i < NI; i++) begin
      if (!fault && wr && commit_mask[i]) begin
        for (int b = 0; b < 4; b++) begin
          if (s[b]) model_mem[i][idx][8*b +: 8] = d[8*b +: 8];
        end
      end
      e.is_load    = rd;
      e.is_fault   = fault;
      e.rdata      = (fault || !rd) ? 32'd0 : model_mem[i][idx];
      e.addr       = a;
      e.accept_cyc = cyc + 1;
      e.id         = txn_id;
      sb_q[i].push_back(e);
    end
  endtask

  // One full 4-phase transaction; `hold` extra cycles keep the request high
  // after every instance has answered.
  task automatic issue(input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s, input int hold);
    int  target [NI];
    bit  done;
    @(negedge clk);
    for (int i = 0; i < NI; i++) target[i] = resp_cnt[i] + 1;
    push_expect(rd, wr, a, d, s, '1);
    mem_read  = rd;
    mem_write = wr;
    addr      = a;
    wdata     = d;
    wstrb     = s;
    done      = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      // Bus contents after accept must not matter.
      addr  = $urandom;
      wdata = $urandom;
      wstrb = 4'($urandom);
      done  = 1'b1;
      for (int i = 0; i < NI; i++) if (resp_cnt[i] < target[i]) done = 1'b0;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL timeout id=%0d no ready within 40 cycles, required ready", txn_id);
    end
    repeat (hold) @(negedge clk);
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    int w;
    r = $urandom_range(0, 99);
    if (r < 70) begin
      w = $urandom_range(0, 16);
      if (w == 16) w = DEPTH - 1;
      return BASE + 32'(w * 4);
    end else if (r < 80) begin
      return BASE + 32'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
    end else if (r < 90) begin
      return BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 1000) * 4);
    end
    return BASE - 32'($urandom_range(1, 1000) * 4);
  endfunction

  initial begin
    int          r;
    logic [31:0] a;
    for (int i = 0; i < NI; i++) resp_cnt[i] = 0;
    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
    addr = 32'd0; wdata = 32'd0; wstrb = 4'd0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (ready_v[i] !== 1'b0 || err_v[i] !== 1'b0 || rdata_v[i] !== 32'd0) begin
        errors++;
        $display("FAIL reset_state inst=%0d got ready=%b err=%b rdata=%h, required 0 0 0",
                 i, ready_v[i], err_v[i], rdata_v[i]);
      end
    end
    rst = 1'b0;

    // Give every word the random traffic may load a known value.
    for (int w = 0; w < 16; w++) issue(0, 1, BASE + 32'(w * 4), $urandom, 4'hF, 0);
    issue(0, 1, BASE + 32'(4 * (DEPTH - 1)), $urandom, 4'hF, 0);

    // Full-word store then load, then a byte-masked merge.
    issue(0, 1, 32'h1001_0004, 32'hDEAD_BEEF, 4'hF, 0);
    issue(1, 0, 32'h1001_0004, 32'h0, 4'h0, 0);
    issue(0, 1, 32'h1001_0004, 32'h1122_3344, 4'b0101, 0);
    issue(1, 0, 32'h1001_0004, 32'h0, 4'h0, 0);

    // Faults: misaligned, past the end, below the base, read+write together.
    issue(1, 0, 32'h1001_0002, 32'h0, 4'h0, 0);
    issue(1, 0, 32'h1001_0200, 32'h0, 4'h0, 0);
    issue(1, 0, 32'h1000_FFFC, 32'h0, 4'h0, 0);
    issue(1, 1, 32'h1001_0004, 32'h0, 4'hF, 0);
    issue(1, 0, 32'h1001_0004, 32'h0, 4'h0, 0);
    // Empty byte mask and the last valid word.
    issue(0, 1, 32'h1001_0004, 32'hFFFF_FFFF, 4'h0, 0);
    issue(1, 0, 32'h1001_0004, 32'h0, 4'h0, 0);
    issue(1, 0, BASE + 32'(4 * (DEPTH - 1)), 32'h0, 4'h0, 0);

    // Request held long after ready, then an immediate follow-up request.
    issue(1, 0, 32'h1001_0004, 32'h0, 4'h0, 10);
    issue(1, 0, 32'h1001_0000, 32'h0, 4'h0, 0);

    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 19);
      a = rand_addr();
      if (r == 0)       issue(1, 1, a, $urandom, 4'($urandom), $urandom_range(0, 2));
      else if (r < 10)  issue(1, 0, a, $urandom, 4'($urandom), $urandom_range(0, 2));
      else              issue(0, 1, a, $urandom, 4'($urandom), $urandom_range(0, 2));
    end

    // Reset in the middle of a store to a word holding zero.
    issue(0, 1, 32'h1001_0008, 32'h0, 4'hF, 0);
    issue(1, 0, 32'h1001_0004, 32'h0, 4'h0, 0);
    @(negedge clk);
    // Only the zero-wait instance commits on the accept edge; the others
    // are still in WAIT when reset hits, so their store is dropped.
    push_expect(0, 1, 32'h1001_0008, 32'hCAFE_F00D, 4'hF, 3'b010);
    mem_write = 1'b1; addr = 32'h1001_0008; wdata = 32'hCAFE_F00D; wstrb = 4'hF;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (ready_v[i] !== 1'b0 || err_v[i] !== 1'b0 || rdata_v[i] !== 32'd0) begin
        errors++;
        $display("FAIL async_reset inst=%0d got ready=%b err=%b rdata=%h, required 0 0 0",
                 i, ready_v[i], err_v[i], rdata_v[i]);
      end
    end
    checks++;
    if (sb_q[1].size() != 0) begin
      errors++;
      $display("FAIL ws0_store_resp pending=%0d, required 0", sb_q[1].size());
    end
    for (int i = 0; i < NI; i++) sb_q[i].delete();
    mem_write = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    issue(1, 0, 32'h1001_0008, 32'h0, 4'h0, 0);
    issue(0, 1, 32'h1001_000C, 32'h0BAD_CAFE, 4'hF, 0);
    issue(1, 0, 32'h1001_000C, 32'h0, 4'h0, 0);

    repeat (8) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (sb_q[i].size() != 0) begin
        errors++;
        $display("FAIL leftover inst=%0d pending=%0d, required 0", i, sb_q[i].size());
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
